// File: rtl/i2c_adc_responder.sv
// i2c_adc_responder: I2C target emulating the PmodAD2 4-channel 12-bit ADC
module i2c_adc_responder #(
  parameter logic [6:0] ADDR    = 7'h28,
  parameter logic [7:0] CFG_RST = 8'hF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  input  logic [11:0] ch0,
  input  logic [11:0] ch1,
  input  logic [11:0] ch2,
  input  logic [11:0] ch3,
  output logic [7:0]  cfg,
  output logic        busy
);
  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_BYTE, ST_WR_ACK,
    ST_RD_HI, ST_RD_ACK_HI, ST_RD_LO, ST_RD_ACK_LO, ST_IGNORE
  } state_t;
  state_t      state;
  logic [1:0]  scl_s, sda_s, ptr, nxt, sel, lo;
  logic        scl_q, sda_q, scl_r, scl_f, start, stop, sd, oe, rw, ph, ack;
  logic [2:0]  cnt;
  logic [6:0]  sr;
  logic [3:0]  en;
  logic [11:0] smp;
  logic [15:0] tx, word;
  assign sda   = oe ? 1'b0 : 1'bz;
  assign sd    = sda_s[1];
  assign scl_r = scl_s[1] & ~scl_q;
  assign scl_f = ~scl_s[1] & scl_q;
  assign start = scl_s[1] & scl_q & sda_q & ~sd;
  assign stop  = scl_s[1] & scl_q & ~sda_q & sd;
  assign en    = cfg[7:4];
  always_comb begin
    nxt = en[ptr] ? ptr : 2'd0;
    for (int i = 3; i >= 1; i--) if (en[ptr + 2'(i)]) nxt = ptr + 2'(i);
  end
  // sr[6:3] holds cfg[7:4] of the byte completing on this rising edge
  assign lo   = sr[3] ? 2'd0 : sr[4] ? 2'd1 : sr[5] ? 2'd2 : sr[6] ? 2'd3 : 2'd0;
  assign sel  = (state == ST_RD_ACK_LO) ? nxt : ptr;
  assign smp  = sel == 2'd0 ? ch0 : sel == 2'd1 ? ch1 : sel == 2'd2 ? ch2 : ch3;
  assign word = {2'b00, sel, smp};
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], scl};
      sda_s <= {sda_s[0], sda};
      scl_q <= scl_s[1];
      sda_q <= sda_s[1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cfg   <= CFG_RST;
      busy  <= 1'b0;
      oe    <= 1'b0;
      ptr   <= 2'd0;
      cnt   <= 3'd0;
      sr    <= 7'd0;
      tx    <= 16'd0;
      rw    <= 1'b0;
      ph    <= 1'b0;
      ack   <= 1'b0;
    end else if (start) begin
      state <= ST_ADDR;
      cnt   <= 3'd0;
      busy  <= 1'b0;
      oe    <= 1'b0;
    end else if (stop) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      oe    <= 1'b0;
    end else if (scl_r) begin
      sr  <= {sr[5:0], sd};
      ack <= ~sd;
      if (state == ST_ADDR || state == ST_WR_BYTE) cnt <= cnt + 3'd1;
      if (state == ST_ADDR && cnt == 3'd7) begin
        state <= (sr == ADDR) ? ST_ADDR_ACK : ST_IGNORE;
        busy  <= (sr == ADDR);
        rw    <= sd;
        ph    <= 1'b0;
      end
      if (state == ST_WR_BYTE && cnt == 3'd7) begin
        cfg   <= {sr, sd};
        ptr   <= lo;
        state <= ST_WR_ACK;
        ph    <= 1'b0;
      end
    end else if (scl_f) begin
      case (state)
        ST_ADDR_ACK, ST_WR_ACK: begin
          // first falling edge starts the ACK pulse, second one ends it
          if (!ph) begin
            oe <= 1'b1;
            ph <= 1'b1;
          end else begin
            cnt <= 3'd0;
            if (state == ST_ADDR_ACK && rw) begin
              tx    <= word;
              oe    <= ~word[15];
              state <= ST_RD_HI;
            end else begin
              oe    <= 1'b0;
              state <= ST_WR_BYTE;
            end
          end
        end
        ST_RD_HI, ST_RD_LO: begin
          cnt <= cnt + 3'd1;
          tx  <= {tx[14:0], 1'b0};
          oe  <= (cnt == 3'd7) ? 1'b0 : ~tx[14];
          if (cnt == 3'd7) state <= (state == ST_RD_HI) ? ST_RD_ACK_HI : ST_RD_ACK_LO;
        end
        ST_RD_ACK_HI: begin
          cnt   <= 3'd0;
          oe    <= ack & ~tx[15];
          state <= ack ? ST_RD_LO : ST_IGNORE;
        end
        ST_RD_ACK_LO: begin
          cnt   <= 3'd0;
          oe    <= ack & ~word[15];
          state <= ack ? ST_RD_HI : ST_IGNORE;
          if (ack) begin
            ptr <= nxt;
            tx  <= word;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
